wb_b3_burst_master: RTL and testbench

//   Wishbone B3 bus master that turns one request (address, beat count, direction)

---
 rtl/wb_b3_burst_master.sv | 179 +++++++++++++++++
 tb/tb_wb_b3_burst_master.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_b3_burst_master.sv
// ============================================================================
// Module   : wb_b3_burst_master
// Brief    : Wishbone B3 master issuing linear incrementing bursts or classic cycles.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_b3_burst_master #(
    parameter int dw      = 32,
    parameter int aw      = 32,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_we_i,
    input  logic [aw-1:0]    req_adr_i,
    input  logic [LEN_W-1:0] req_len_i,
    input  logic [dw-1:0]    wr_dat_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    output logic [dw-1:0]    rd_dat_o,
    output logic             rd_valid_o,
    output logic             rd_last_o,
    output logic             done_o,
    output logic             err_o,
    output logic [aw-1:0]    wb_adr_o,
    output logic [1:0]       wb_bte_o,
    output logic [2:0]       wb_cti_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    output logic [3:0]       wb_sel_o,
    output logic [dw-1:0]    wb_dat_o,
    input  logic             wb_ack_i,
    input  logic             wb_err_i,
    input  logic             wb_rty_i,
    input  logic [dw-1:0]    wb_dat_i
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BURST = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int              TO_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

    logic [1:0]       state_q, state_d;
    logic             we_q, we_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [aw-1:0]    adr_q, adr_d;
    logic [2:0]       cti_q, cti_d;
    logic             cyc_q, cyc_d;
    logic             err_q, err_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic             rd_valid_q, rd_last_q;
    logic [dw-1:0]    rd_dat_q;

    logic w_stb, w_fault, w_ack, w_final, w_to_hit;
    logic w_unused_adr;

    assign w_unused_adr = ^req_adr_i[1:0];

    // Writes only strobe when a data beat is actually available
    assign w_stb    = cyc_q & (~we_q | wr_valid_i);
    assign w_fault  = w_stb & (wb_err_i | wb_rty_i);
    assign w_ack    = w_stb & wb_ack_i & ~(wb_err_i | wb_rty_i);
    assign w_final  = (cnt_q == len_q);
    assign w_to_hit = (TIMEOUT != 0) && ((to_q + TO_W'(1)) == TO_MAX);

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        cti_d   = cti_q;
        cyc_d   = cyc_q;
        err_d   = err_q;
        to_d    = to_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    state_d = BURST;
                    we_d    = req_we_i;
                    len_d   = req_len_i;
                    adr_d   = {req_adr_i[aw-1:2], 2'b00};
                    cnt_d   = '0;
                    cti_d   = (req_len_i == '0) ? 3'b000 : 3'b010;
                    cyc_d   = 1'b1;
                    err_d   = 1'b0;
                    to_d    = '0;
                end
            end
            BURST: begin
                if (w_fault) begin
                    state_d = DONE;
                    cyc_d   = 1'b0;
                    cti_d   = 3'b000;
                    err_d   = 1'b1;
                end else if (w_ack) begin
                    adr_d = adr_q + aw'(4);
                    cnt_d = cnt_q + LEN_W'(1);
                    to_d  = '0;
                    if (w_final) begin
                        state_d = DONE;
                        cyc_d   = 1'b0;
                        cti_d   = 3'b000;
                    end else if ((cnt_q + LEN_W'(1)) == len_q) begin
                        cti_d = 3'b111;
                    end
                end else if (w_to_hit) begin
                    state_d = DONE;
                    cyc_d   = 1'b0;
                    cti_d   = 3'b000;
                    err_d   = 1'b1;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            len_q      <= '0;
            cnt_q      <= '0;
            adr_q      <= '0;
            cti_q      <= 3'b000;
            cyc_q      <= 1'b0;
            err_q      <= 1'b0;
            to_q       <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_dat_q   <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            adr_q      <= adr_d;
            cti_q      <= cti_d;
            cyc_q      <= cyc_d;
            err_q      <= err_d;
            to_q       <= to_d;
            rd_valid_q <= w_ack & ~we_q;
            rd_last_q  <= w_ack & ~we_q & w_final;
            if (w_ack & ~we_q) begin
                rd_dat_q <= wb_dat_i;
            end
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign wr_ready_o  = w_ack & we_q;
    assign rd_dat_o    = rd_dat_q;
    assign rd_valid_o  = rd_valid_q;
    assign rd_last_o   = rd_last_q;
    assign done_o      = (state_q == DONE);
    assign err_o       = (state_q == DONE) & err_q;
    assign wb_adr_o    = adr_q;
    assign wb_bte_o    = 2'b00;
    assign wb_cti_o    = cti_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = w_stb;
    assign wb_we_o     = we_q;
    assign wb_sel_o    = 4'hf;
    assign wb_dat_o    = (cyc_q & we_q) ? wr_dat_i : '0;

endmodule

`default_nettype wire

// File: tb/tb_wb_b3_burst_master.sv
// ============================================================================
// Module   : tb_wb_b3_burst_master
// Brief    : Directed self-checking bench with a small Wishbone RAM slave model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wb_b3_burst_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [31:0] req_adr = '0;
    logic [3:0]  req_len = '0;
    logic [31:0] wr_dat = '0;
    logic        wr_valid = 1'b0;
    logic        req_ready, wr_ready, rd_valid, rd_last, done, err;
    logic [31:0] rd_dat, wb_adr, wb_dat_o, wb_dat_i;
    logic [1:0]  wb_bte;
    logic [2:0]  wb_cti;
    logic [3:0]  wb_sel;
    logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err, wb_rty;

    logic        sl_noack = 1'b0, sl_rty = 1'b0;
    logic        pl_we = 1'b0;
    logic [9:0]  pl_idx = '0;
    logic [31:0] pl_dat = '0;
    logic [31:0] mem [1024];

    int          ack_cnt = 0, rd_cnt = 0;
    logic [31:0] ack_adr [64];
    logic [2:0]  ack_cti [64];
    logic [31:0] rd_buf [64];
    logic        rd_last_buf [64];
    logic        rd_done_buf [64];

    int n_pass = 0, n_total = 0;

    always #5 clk = ~clk;

    wb_b3_burst_master #(.dw(32), .aw(32), .LEN_W(4), .TIMEOUT(16)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_adr_i(req_adr), .req_len_i(req_len),
        .wr_dat_i(wr_dat), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
        .rd_dat_o(rd_dat), .rd_valid_o(rd_valid), .rd_last_o(rd_last),
        .done_o(done), .err_o(err),
        .wb_adr_o(wb_adr), .wb_bte_o(wb_bte), .wb_cti_o(wb_cti),
        .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_sel_o(wb_sel),
        .wb_dat_o(wb_dat_o), .wb_ack_i(wb_ack), .wb_err_i(wb_err),
        .wb_rty_i(wb_rty), .wb_dat_i(wb_dat_i)
    );

    // 4 KiB RAM slave answering in the same cycle as the strobe
    logic sl_sel, sl_inrange;
    assign sl_sel     = wb_cyc & wb_stb;
    assign sl_inrange = (wb_adr[31:12] == 20'h0);
    assign wb_ack     = sl_sel & sl_inrange & ~sl_noack & ~sl_rty;
    assign wb_err     = sl_sel & ~sl_inrange;
    assign wb_rty     = sl_sel & sl_inrange & sl_rty;
    assign wb_dat_i   = mem[wb_adr[11:2]];

    always @(posedge clk) begin
        if (pl_we)
            mem[pl_idx] <= pl_dat;
        else if (wb_ack && wb_we)
            mem[wb_adr[11:2]] <= wb_dat_o;
    end

    always @(posedge clk) begin
        if (sl_sel && wb_ack && !wb_err && !wb_rty) begin
            ack_adr[ack_cnt % 64] <= wb_adr;
            ack_cti[ack_cnt % 64] <= wb_cti;
            ack_cnt <= ack_cnt + 1;
        end
        if (rd_valid) begin
            rd_buf[rd_cnt % 64]      <= rd_dat;
            rd_last_buf[rd_cnt % 64] <= rd_last;
            rd_done_buf[rd_cnt % 64] <= done;
            rd_cnt <= rd_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] dat);
        @(negedge clk);
        pl_we = 1'b1; pl_idx = idx; pl_dat = dat;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [31:0] adr, input logic [3:0] len);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_adr = adr; req_len = len;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max, output int cycles, output logic e);
        cycles = 0;
        while (!done && cycles < max) begin
            @(negedge clk);
            cycles++;
        end
        chk(tag, {31'b0, done}, 32'd1);
        e = err;
    endtask

    initial begin
        int   cyc_n, a0, r0, idx, stb_bad, n;
        logic e;

        // Reset held across clock edges
        repeat (2) @(negedge clk);
        chk("rst_cyc", {31'b0, wb_cyc}, 0);
        chk("rst_stb", {31'b0, wb_stb}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_rdv", {31'b0, rd_valid}, 0);
        chk("rst_ready", {31'b0, req_ready}, 1);
        chk("rst_cti", {29'b0, wb_cti}, 0);
        rst_n = 1'b1;

        preload(10'h040, 32'hAAAA_0001);
        preload(10'h041, 32'hBBBB_0002);
        preload(10'h042, 32'hCCCC_0003);
        preload(10'h043, 32'hDDDD_0004);

        // Read burst of 4 beats at 0x100
        a0 = ack_cnt; r0 = rd_cnt;
        do_req(1'b0, 32'h0000_0103, 4'd3);
        wait_done("rd4_done", 50, cyc_n, e);
        chk("rd4_err", {31'b0, e}, 0);
        chk("rd4_cycles", cyc_n, 4);
        chk("rd4_acks", ack_cnt - a0, 4);
        chk("rd4_adr0", ack_adr[a0 % 64], 32'h100);
        chk("rd4_adr1", ack_adr[(a0 + 1) % 64], 32'h104);
        chk("rd4_adr2", ack_adr[(a0 + 2) % 64], 32'h108);
        chk("rd4_adr3", ack_adr[(a0 + 3) % 64], 32'h10C);
        chk("rd4_cti0", {29'b0, ack_cti[a0 % 64]}, 3'b010);
        chk("rd4_cti1", {29'b0, ack_cti[(a0 + 1) % 64]}, 3'b010);
        chk("rd4_cti2", {29'b0, ack_cti[(a0 + 2) % 64]}, 3'b010);
        chk("rd4_cti3", {29'b0, ack_cti[(a0 + 3) % 64]}, 3'b111);
        @(negedge clk);
        chk("rd4_beats", rd_cnt - r0, 4);
        chk("rd4_dat0", rd_buf[r0 % 64], 32'hAAAA_0001);
        chk("rd4_dat1", rd_buf[(r0 + 1) % 64], 32'hBBBB_0002);
        chk("rd4_dat2", rd_buf[(r0 + 2) % 64], 32'hCCCC_0003);
        chk("rd4_dat3", rd_buf[(r0 + 3) % 64], 32'hDDDD_0004);
        chk("rd4_last_mid", {31'b0, rd_last_buf[(r0 + 2) % 64]}, 0);
        chk("rd4_last", {31'b0, rd_last_buf[(r0 + 3) % 64]}, 1);
        chk("rd4_last_done", {31'b0, rd_done_buf[(r0 + 3) % 64]}, 1);
        chk("rd4_done_1cyc", {31'b0, done}, 0);
        chk("rd4_ready", {31'b0, req_ready}, 1);

        // Single-beat classic write
        a0 = ack_cnt;
        wr_valid = 1'b1; wr_dat = 32'hDEAD_BEEF;
        do_req(1'b1, 32'h0000_0020, 4'd0);
        wait_done("wr1_done", 50, cyc_n, e);
        wr_valid = 1'b0;
        chk("wr1_err", {31'b0, e}, 0);
        chk("wr1_cycles", cyc_n, 1);
        chk("wr1_acks", ack_cnt - a0, 1);
        chk("wr1_cti", {29'b0, ack_cti[a0 % 64]}, 3'b000);
        chk("wr1_adr", ack_adr[a0 % 64], 32'h20);
        chk("wr1_mem", mem[8], 32'hDEAD_BEEF);

        // 8-beat write with data availability toggling every cycle
        a0 = ack_cnt; idx = 0; stb_bad = 0; n = 0;
        do_req(1'b1, 32'h0000_0000, 4'd7);
        while (!done && n < 100) begin
            wr_valid = ~wr_valid;
            wr_dat   = 32'h5000_0000 + idx;
            #1;
            if (wb_stb !== (wb_cyc & wr_valid)) stb_bad++;
            if (wr_ready) idx++;
            @(negedge clk);
            n++;
        end
        wr_valid = 1'b0;
        chk("wr8_done", {31'b0, done}, 1);
        chk("wr8_err", {31'b0, err}, 0);
        chk("wr8_stb_follow", stb_bad, 0);
        chk("wr8_consumed", idx, 8);
        chk("wr8_acks", ack_cnt - a0, 8);
        chk("wr8_cti_last", {29'b0, ack_cti[(a0 + 7) % 64]}, 3'b111);
        for (int i = 0; i < 8; i++)
            chk($sformatf("wr8_mem%0d", i), mem[i], 32'h5000_0000 + i);

        // Out-of-range read: bus error
        r0 = rd_cnt;
        do_req(1'b0, 32'h0001_0000, 4'd3);
        wait_done("berr_done", 50, cyc_n, e);
        chk("berr_err", {31'b0, e}, 1);
        chk("berr_cycles", cyc_n, 1);
        chk("berr_cyc_low", {31'b0, wb_cyc}, 0);
        @(negedge clk);
        chk("berr_no_rd", rd_cnt - r0, 0);

        // Silent slave: timeout after 16 burst cycles
        sl_noack = 1'b1;
        do_req(1'b0, 32'h0000_0000, 4'd3);
        wait_done("to_done", 40, cyc_n, e);
        chk("to_err", {31'b0, e}, 1);
        chk("to_cycles", cyc_n, 16);
        sl_noack = 1'b0;

        // Retry is reported as an error
        sl_rty = 1'b1;
        do_req(1'b1, 32'h0000_0040, 4'd2);
        wr_valid = 1'b1;
        wait_done("rty_done", 40, cyc_n, e);
        wr_valid = 1'b0;
        chk("rty_err", {31'b0, e}, 1);
        sl_rty = 1'b0;

        // Reset asserted mid-burst
        sl_noack = 1'b1;
        do_req(1'b0, 32'h0000_0000, 4'd3);
        repeat (3) @(negedge clk);
        chk("mid_cyc_pre", {31'b0, wb_cyc}, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_cyc", {31'b0, wb_cyc}, 0);
        chk("mid_stb", {31'b0, wb_stb}, 0);
        chk("mid_done", {31'b0, done}, 0);
        chk("mid_rdv", {31'b0, rd_valid}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sl_noack = 1'b0;
        @(negedge clk);
        chk("mid_ready", {31'b0, req_ready}, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
